// File: rtl/pio_poll_pkg.sv
// Shared types for the PIO poll master: FSM state encoding.
package pio_poll_pkg;

    localparam int unsigned STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        IDLE    = 3'd0,
        RD_REQ  = 3'd1,
        RD_WAIT = 3'd2,
        EVAL    = 3'd3,
        WR_REQ  = 3'd4
    } poll_state_e;

endpackage

// File: rtl/pio_debounce_filter.sv
// Debounce filter: commits a sampled word once it has been seen DEBOUNCE_N
// consecutive times while differing from the current stable word.
module pio_debounce_filter #(
    parameter int unsigned          DATA_W     = 4,
    parameter int unsigned          DEBOUNCE_N = 3,
    parameter logic [DATA_W-1:0]    RESET_VAL  = 4'hF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sample_valid,
    input  logic [DATA_W-1:0] sample,
    output logic [DATA_W-1:0] stable,
    output logic              change_pulse,
    output logic              commit_c
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_N + 1);

    logic [DATA_W-1:0] candidate;
    logic [DATA_W-1:0] candidate_nxt;
    logic [DATA_W-1:0] stable_nxt;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_nxt;

    // A commit always takes the current sample, so the counter never exceeds DEBOUNCE_N.
    always_comb begin
        candidate_nxt = candidate;
        stable_nxt    = stable;
        cnt_nxt       = cnt;
        commit_c      = 1'b0;
        if (sample_valid) begin
            if (sample == stable) begin
                cnt_nxt = '0;
            end else begin
                if (sample == candidate) begin
                    cnt_nxt = cnt + CNT_W'(1);
                end else begin
                    candidate_nxt = sample;
                    cnt_nxt       = CNT_W'(1);
                end
                if (cnt_nxt == CNT_W'(DEBOUNCE_N)) begin
                    commit_c   = 1'b1;
                    stable_nxt = sample;
                    cnt_nxt    = '0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stable       <= RESET_VAL;
            candidate    <= RESET_VAL;
            cnt          <= '0;
            change_pulse <= 1'b0;
        end else begin
            stable       <= stable_nxt;
            candidate    <= candidate_nxt;
            cnt          <= cnt_nxt;
            change_pulse <= commit_c;
        end
    end

endmodule

// File: rtl/pio_poll_master.sv
// Avalon-MM initiator: polls an input PIO, debounces the word and writes each
// committed change to an output PIO. One transaction outstanding at a time.
module pio_poll_master
    import pio_poll_pkg::*;
#(
    parameter int unsigned       DATA_W      = 4,
    parameter int unsigned       ADDR_W      = 2,
    parameter logic [ADDR_W-1:0] SRC_ADDR    = '0,
    parameter logic [ADDR_W-1:0] DST_ADDR    = '0,
    parameter int unsigned       POLL_CYCLES = 50000,
    parameter int unsigned       DEBOUNCE_N  = 3,
    parameter int unsigned       TIMEOUT     = 16,
    parameter logic [DATA_W-1:0] RESET_VAL   = 4'hF,
    parameter bit                INVERT      = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              err_clr,
    output logic [ADDR_W-1:0] avm_address,
    output logic              avm_read,
    output logic              avm_write,
    output logic [DATA_W-1:0] avm_writedata,
    input  logic              avm_waitrequest,
    input  logic [DATA_W-1:0] avm_readdata,
    input  logic              avm_readdatavalid,
    output logic [DATA_W-1:0] stable_value,
    output logic              change_pulse,
    output logic              timeout_err
);

    localparam int unsigned       POLL_W  = $clog2(POLL_CYCLES);
    localparam int unsigned       TO_W    = $clog2(TIMEOUT);
    localparam logic [DATA_W-1:0] WR_MASK = {DATA_W{INVERT}};

    poll_state_e       state;
    poll_state_e       state_nxt;
    logic [POLL_W-1:0] poll_cnt;
    logic              poll_tick_c;
    logic [TO_W-1:0]   to_cnt;
    logic [TO_W-1:0]   to_cnt_nxt;
    logic              capture_c;
    logic              timeout_hit_c;
    logic              eval_c;
    logic              commit_c;
    logic [DATA_W-1:0] sample_q;

    assign poll_tick_c = enable && (poll_cnt == POLL_W'(POLL_CYCLES - 1));

    // Free-running poll timer; ticks arriving outside IDLE are simply lost.
    always_ff @(posedge clk) begin
        if (reset || !enable || poll_tick_c) begin
            poll_cnt <= '0;
        end else begin
            poll_cnt <= poll_cnt + POLL_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        to_cnt_nxt    = to_cnt;
        capture_c     = 1'b0;
        timeout_hit_c = 1'b0;
        eval_c        = 1'b0;
        case (state)
            IDLE: begin
                if (poll_tick_c) begin
                    state_nxt = RD_REQ;
                end
            end
            RD_REQ: begin
                if (!avm_waitrequest) begin
                    state_nxt  = RD_WAIT;
                    to_cnt_nxt = '0;
                end
            end
            RD_WAIT: begin
                if (avm_readdatavalid) begin
                    capture_c = 1'b1;
                    state_nxt = EVAL;
                end else if (to_cnt == TO_W'(TIMEOUT - 1)) begin
                    timeout_hit_c = 1'b1;
                    state_nxt     = IDLE;
                end else begin
                    to_cnt_nxt = to_cnt + TO_W'(1);
                end
            end
            EVAL: begin
                eval_c    = 1'b1;
                state_nxt = commit_c ? WR_REQ : IDLE;
            end
            WR_REQ: begin
                if (!avm_waitrequest) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Bus command registers follow the next state so commands drop the cycle after acceptance.
    always_ff @(posedge clk) begin
        if (reset) begin
            to_cnt        <= '0;
            sample_q      <= '0;
            avm_read      <= 1'b0;
            avm_write     <= 1'b0;
            avm_address   <= '0;
            avm_writedata <= '0;
            timeout_err   <= 1'b0;
        end else begin
            to_cnt    <= to_cnt_nxt;
            avm_read  <= (state_nxt == RD_REQ);
            avm_write <= (state_nxt == WR_REQ);
            if (state_nxt == RD_REQ) begin
                avm_address <= SRC_ADDR;
            end else if (state_nxt == WR_REQ) begin
                avm_address <= DST_ADDR;
            end else begin
                avm_address <= '0;
            end
            if (capture_c) begin
                sample_q <= avm_readdata;
            end
            if (eval_c && commit_c) begin
                avm_writedata <= sample_q ^ WR_MASK;
            end
            if (timeout_hit_c) begin
                timeout_err <= 1'b1;
            end else if (err_clr) begin
                timeout_err <= 1'b0;
            end
        end
    end

    pio_debounce_filter #(
        .DATA_W     (DATA_W),
        .DEBOUNCE_N (DEBOUNCE_N),
        .RESET_VAL  (RESET_VAL)
    ) u_filter (
        .clk          (clk),
        .reset        (reset),
        .sample_valid (eval_c),
        .sample       (sample_q),
        .stable       (stable_value),
        .change_pulse (change_pulse),
        .commit_c     (commit_c)
    );

endmodule

// File: tb/tb_pio_poll_master.sv
// Directed bench for pio_poll_master with a behavioural Avalon PIO slave.
module tb_pio_poll_master;

    localparam int unsigned DATA_W = 4;
    localparam int unsigned ADDR_W = 2;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              enable = 1'b0;
    logic              err_clr = 1'b0;
    logic [ADDR_W-1:0] avm_address;
    logic              avm_read;
    logic              avm_write;
    logic [DATA_W-1:0] avm_writedata;
    logic              avm_waitrequest;
    logic [DATA_W-1:0] avm_readdata;
    logic              avm_readdatavalid;
    logic [DATA_W-1:0] stable_value;
    logic              change_pulse;
    logic              timeout_err;

    pio_poll_master #(
        .DATA_W      (DATA_W),
        .ADDR_W      (ADDR_W),
        .SRC_ADDR    (2'd1),
        .DST_ADDR    (2'd2),
        .POLL_CYCLES (8),
        .DEBOUNCE_N  (3),
        .TIMEOUT     (16),
        .RESET_VAL   (4'hF),
        .INVERT      (1'b1)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .enable            (enable),
        .err_clr           (err_clr),
        .avm_address       (avm_address),
        .avm_read          (avm_read),
        .avm_write         (avm_write),
        .avm_writedata     (avm_writedata),
        .avm_waitrequest   (avm_waitrequest),
        .avm_readdata      (avm_readdata),
        .avm_readdatavalid (avm_readdatavalid),
        .stable_value      (stable_value),
        .change_pulse      (change_pulse),
        .timeout_err       (timeout_err)
    );

    initial forever #5 clk = ~clk;

    int cyc = 0;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Slave model: configurable read latency (0 = never respond) and command stalls.
    int               rd_latency = 1;
    int               stall_rd = 0;
    int               stall_wr = 0;
    int               pend = 0;
    logic [DATA_W-1:0] slave_data = 4'hF;
    bit               accepted;

    initial begin
        avm_waitrequest   = 1'b0;
        avm_readdatavalid = 1'b0;
        avm_readdata      = '0;
        forever begin
            @(negedge clk);
            accepted = avm_read && !avm_waitrequest;
            @(posedge clk);
            #1;
            avm_readdatavalid = 1'b0;
            if (accepted && rd_latency > 0) pend = rd_latency;
            if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    avm_readdatavalid = 1'b1;
                    avm_readdata      = slave_data;
                end
            end
            if (avm_read && stall_rd > 0) begin
                avm_waitrequest = 1'b1;
                stall_rd--;
            end else if (avm_write && stall_wr > 0) begin
                avm_waitrequest = 1'b1;
                stall_wr--;
            end else begin
                avm_waitrequest = 1'b0;
            end
        end
    end

    // Bus monitor
    int                rd_acc = 0, wr_acc = 0, pulses = 0, overlap = 0;
    int                rd_stall = 0, wr_stall = 0, hold_err = 0;
    int                acc_cyc = 0;
    logic [ADDR_W-1:0] wr_addr = '0;
    logic [DATA_W-1:0] wr_data = '0;
    bit                prev_stalled = 1'b0;
    logic              p_rd, p_wr;
    logic [ADDR_W-1:0] p_addr;
    logic [DATA_W-1:0] p_data;

    initial forever begin
        @(negedge clk);
        if (avm_read && avm_write) overlap++;
        if (!reset && prev_stalled &&
            (avm_read !== p_rd || avm_write !== p_wr ||
             avm_address !== p_addr || avm_writedata !== p_data)) hold_err++;
        prev_stalled = (avm_read || avm_write) && avm_waitrequest;
        p_rd   = avm_read;
        p_wr   = avm_write;
        p_addr = avm_address;
        p_data = avm_writedata;
        if (avm_read && !avm_waitrequest) begin
            rd_acc++;
            acc_cyc = cyc + 1;
        end
        if (avm_write && !avm_waitrequest) begin
            wr_acc++;
            wr_addr = avm_address;
            wr_data = avm_writedata;
        end
        if (avm_read && avm_waitrequest) rd_stall++;
        if (avm_write && avm_waitrequest) wr_stall++;
        if (change_pulse) pulses++;
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic apply_reset();
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        tick();
        check_eq("rst_stable", 32'(stable_value), 32'hF);
        check_eq("rst_read", 32'(avm_read), 32'h0);
        check_eq("rst_write", 32'(avm_write), 32'h0);
        check_eq("rst_addr", 32'(avm_address), 32'h0);
        check_eq("rst_wdata", 32'(avm_writedata), 32'h0);
        check_eq("rst_pulse", 32'(change_pulse), 32'h0);
        check_eq("rst_err", 32'(timeout_err), 32'h0);
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic first_read_check(input string tag);
        int n = 0;
        do begin
            tick();
            n++;
        end while (!avm_read && n < 50);
        check_eq(tag, 32'(n), 32'd9);
        check_eq({tag, "_addr"}, 32'(avm_address), 32'h1);
    endtask

    task automatic wait_read();
        int  start = rd_acc;
        bit  ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (rd_acc != start) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check_eq("read_seen", 32'(ok), 32'h1);
    endtask

    task automatic poll_once(input logic [DATA_W-1:0] d);
        slave_data = d;
        wait_read();
        repeat (5) tick();
    endtask

    task automatic wait_timeout(input string tag, input int a);
        int seen = -1;
        for (int i = 0; i < 40; i++) begin
            if (timeout_err) begin
                seen = cyc - a;
                break;
            end
            tick();
        end
        check_eq(tag, 32'(seen), 32'd16);
    endtask

    int p0, w0, a0, a1, a2, rs0, ws0;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        enable = 1'b1;

        // Reset, first-read latency, idle polling
        apply_reset();
        first_read_check("first_read");
        p0 = pulses; w0 = wr_acc;
        poll_once(4'hF); a0 = acc_cyc;
        poll_once(4'hF); a1 = acc_cyc;
        poll_once(4'hF); a2 = acc_cyc;
        check_eq("poll_period1", 32'(a1 - a0), 32'd8);
        check_eq("poll_period2", 32'(a2 - a1), 32'd8);
        check_eq("idle_no_write", 32'(wr_acc - w0), 32'd0);
        check_eq("idle_no_pulse", 32'(pulses - p0), 32'd0);
        check_eq("idle_stable", 32'(stable_value), 32'hF);

        // Three identical differing samples commit; latency check on the third
        poll_once(4'hE);
        poll_once(4'hE);
        check_eq("two_no_pulse", 32'(pulses - p0), 32'd0);
        check_eq("two_stable", 32'(stable_value), 32'hF);
        slave_data = 4'hE;
        wait_read();
        tick();
        tick();
        check_eq("eval_stable", 32'(stable_value), 32'hF);
        check_eq("eval_write", 32'(avm_write), 32'h0);
        tick();
        check_eq("commit_stable", 32'(stable_value), 32'hE);
        check_eq("commit_pulse", 32'(change_pulse), 32'h1);
        check_eq("commit_write", 32'(avm_write), 32'h1);
        check_eq("commit_wdata", 32'(avm_writedata), 32'h1);
        check_eq("commit_addr", 32'(avm_address), 32'h2);
        repeat (3) tick();
        check_eq("commit_pulses", 32'(pulses - p0), 32'd1);
        check_eq("commit_writes", 32'(wr_acc - w0), 32'd1);
        check_eq("wr_log_data", 32'(wr_data), 32'h1);
        check_eq("wr_log_addr", 32'(wr_addr), 32'h2);

        // Interrupted run does not commit; a fresh run commits exactly once
        apply_reset();
        p0 = pulses; w0 = wr_acc;
        poll_once(4'hE);
        poll_once(4'hE);
        poll_once(4'hF);
        check_eq("bounce_no_pulse", 32'(pulses - p0), 32'd0);
        check_eq("bounce_no_write", 32'(wr_acc - w0), 32'd0);
        poll_once(4'hE);
        poll_once(4'hE);
        check_eq("rerun_no_pulse", 32'(pulses - p0), 32'd0);
        poll_once(4'hE);
        poll_once(4'hE);
        check_eq("rerun_pulses", 32'(pulses - p0), 32'd1);
        check_eq("rerun_writes", 32'(wr_acc - w0), 32'd1);
        check_eq("rerun_stable", 32'(stable_value), 32'hE);

        // waitrequest held for 5 cycles on both read and write
        apply_reset();
        poll_once(4'hE);
        poll_once(4'hE);
        w0 = wr_acc; rs0 = rd_stall; ws0 = wr_stall;
        stall_rd = 5;
        stall_wr = 5;
        slave_data = 4'hE;
        wait_read();
        repeat (16) tick();
        check_eq("stall_rd_cycles", 32'(rd_stall - rs0), 32'd5);
        check_eq("stall_wr_cycles", 32'(wr_stall - ws0), 32'd5);
        check_eq("stall_hold", 32'(hold_err), 32'd0);
        check_eq("stall_writes", 32'(wr_acc - w0), 32'd1);
        check_eq("stall_wdata", 32'(wr_data), 32'h1);
        check_eq("stall_waddr", 32'(wr_addr), 32'h2);
        check_eq("stall_stable", 32'(stable_value), 32'hE);

        // Read timeout, clear, recovery
        apply_reset();
        rd_latency = 0;
        wait_read();
        wait_timeout("timeout_cycles", acc_cyc);
        check_eq("timeout_stable", 32'(stable_value), 32'hF);
        @(posedge clk);
        #1 err_clr = 1'b1;
        @(posedge clk);
        #1 err_clr = 1'b0;
        tick();
        check_eq("err_cleared", 32'(timeout_err), 32'h0);
        rd_latency = 1;
        p0 = rd_acc;
        poll_once(4'hF);
        check_eq("recover_read", 32'(rd_acc - p0), 32'd1);
        check_eq("recover_err", 32'(timeout_err), 32'h0);

        // Timeout set wins over a simultaneous err_clr
        rd_latency = 0;
        err_clr = 1'b1;
        wait_read();
        wait_timeout("prio_cycles", acc_cyc);
        tick();
        check_eq("prio_cleared", 32'(timeout_err), 32'h0);
        err_clr = 1'b0;

        // Reset inside RD_WAIT, late readdatavalid ignored
        rd_latency = 3;
        slave_data = 4'h0;
        p0 = pulses;
        wait_read();
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        first_read_check("post_abort_read");
        check_eq("abort_stable", 32'(stable_value), 32'hF);
        check_eq("abort_pulse", 32'(pulses - p0), 32'd0);
        rd_latency = 1;

        // enable low keeps the master idle
        apply_reset();
        enable = 1'b0;
        p0 = rd_acc;
        repeat (30) tick();
        check_eq("disabled_reads", 32'(rd_acc - p0), 32'd0);
        enable = 1'b1;

        check_eq("no_overlap", 32'(overlap), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
